dmem_run_ctrl: RTL and testbench

Synthesisable run controller for the single-cycle datapath's data memory. It runs four phases in order: clear memory, preload initial words from a load stream, run the CPU until it halts or a cycle budget expires, then stream out every memory word. It sits beside the datapath and drives the data-memory side port through an external mux selected by busy/cpu_run. It replaces ad-hoc memory initialisation, timeout and dump logic with one parametrised block that works in silicon and in simulation.

---
 rtl/dmem_run_ctrl.sv | 159 +++++++++++++++
 tb/tb_dmem_run_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_run_ctrl.sv
// dmem_run_ctrl: sequences the data memory through clear, preload, CPU run
// with cycle budget, and a handshaked dump of every word.
// Optional feature macro: DMEM_CHECKSUM_EN adds dump_sum, the modulo-2**DATA_W
// sum of all dumped words, cleared when a new sequence starts.
module dmem_run_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int DEPTH       = 32,
  parameter int INIT_WORDS  = 9,
  parameter int TIMEOUT_CYC = 250
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_run,
  input  logic              cpu_halt,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done,
`ifdef DMEM_CHECKSUM_EN
  output logic [DATA_W-1:0] dump_sum,
`endif
  output logic              timeout
);

  // Address counter carries one extra bit so DEPTH == 2**ADDR_W never wraps.
  localparam int AW = ADDR_W + 1;
  localparam int RW = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LAST_INIT = AW'((INIT_WORDS > 0) ? INIT_WORDS - 1 : 0);
  localparam logic [RW-1:0] LAST_RUN  = RW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DUMP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state, nxt;
  logic [AW-1:0]   addr;
  logic [RW-1:0]   rcnt;
  logic            tmo;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next-state decode; start/halt/valid/ready only matter in their own phase
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) nxt = S_CLEAR;
      S_CLEAR: if (addr == LAST_ADDR) nxt = (INIT_WORDS == 0) ? S_RUN : S_LOAD;
      S_LOAD:  if (load_valid && addr == LAST_INIT) nxt = S_RUN;
      S_RUN:   if (cpu_halt || rcnt == LAST_RUN) nxt = S_DUMP;
      S_DUMP:  if (dump_ready && addr == LAST_ADDR) nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end

  // Address / run counters and timeout flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= '0;
      rcnt <= '0;
      tmo  <= 1'b0;
    end else begin
      // run counter is held at 0 outside RUN so every RUN entry starts fresh
      rcnt <= (state == S_RUN) ? rcnt + 1'b1 : '0;
      case (state)
        S_IDLE, S_DONE: if (start) begin
          addr <= '0;
          tmo  <= 1'b0;
        end
        S_CLEAR: addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
        S_LOAD:  if (load_valid) addr <= (addr == LAST_INIT) ? '0 : addr + 1'b1;
        S_RUN: begin
          // halt wins over a coincident budget expiry
          if (cpu_halt)              tmo <= 1'b0;
          else if (rcnt == LAST_RUN) tmo <= 1'b1;
        end
        S_DUMP:  if (dump_ready) addr <= addr + 1'b1;
        default: ;
      endcase
    end
  end

  // Output decode; only LOAD write strobe/data and dump_data follow inputs
  always_comb begin
    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_run    = 1'b0;
    dump_valid = 1'b0;
    dump_addr  = '0;
    dump_data  = '0;
    busy       = 1'b0;
    done       = 1'b0;
    timeout    = tmo;
    case (state)
      S_CLEAR: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = addr[ADDR_W-1:0];
      end
      S_LOAD: begin
        busy       = 1'b1;
        load_ready = 1'b1;
        mem_we     = load_valid;
        mem_addr   = addr[ADDR_W-1:0];
        mem_wdata  = load_data;
      end
      S_RUN: begin
        busy    = 1'b1;
        cpu_run = 1'b1;
      end
      S_DUMP: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
        mem_addr   = addr[ADDR_W-1:0];
        dump_addr  = addr[ADDR_W-1:0];
        dump_data  = mem_rdata;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef DMEM_CHECKSUM_EN
  logic [DATA_W-1:0] sum;

  // Running sum of dumped words, restarted with each new sequence
  always_ff @(posedge clk) begin
    if (!rst_n)                                          sum <= '0;
    else if ((state == S_IDLE || state == S_DONE) && start) sum <= '0;
    else if (state == S_DUMP && dump_ready)              sum <= sum + mem_rdata;
  end

  assign dump_sum = sum;
`endif

endmodule

// File: tb/tb_dmem_run_ctrl.sv
// Directed bench for dmem_run_ctrl with a behavioural data memory.
module tb_dmem_run_ctrl;
  localparam int DW = 32, AWD = 5, DEPTH = 32, NINIT = 9, TO = 250;

  logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic           load_valid = 1'b0, cpu_halt = 1'b0, dump_ready = 1'b0;
  logic [DW-1:0]  load_data = '0;
  logic           load_ready, mem_we, cpu_run, dump_valid, busy, done, timeout;
  logic [AWD-1:0] mem_addr, dump_addr;
  logic [DW-1:0]  mem_wdata, mem_rdata, dump_data;
`ifdef DMEM_CHECKSUM_EN
  logic [DW-1:0]  dump_sum;
`endif

  dmem_run_ctrl #(.DATA_W(DW), .ADDR_W(AWD), .DEPTH(DEPTH), .INIT_WORDS(NINIT),
                  .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_run(cpu_run), .cpu_halt(cpu_halt), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .busy(busy), .done(done),
`ifdef DMEM_CHECKSUM_EN
    .dump_sum(dump_sum),
`endif
    .timeout(timeout));

  always #5 clk = ~clk;

  // behavioural memory: async read, write on rising edge
  logic [DW-1:0] mem [DEPTH];
  initial foreach (mem[i]) mem[i] = '0;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  int unsigned words [NINIT] = '{11, 13, 255, 10, 69, 24, 48, 802, 10};

  int errors = 0, checks = 0;
  int wa[$], da[$];
  logic [DW-1:0] wd[$], dd[$];
  int run_cyc, stab_err, ld_we_err, last_ld_cyc, first_run_cyc;
  logic tout_q, done_q;

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Runs one full start..DONE sequence, logging writes, run cycles and dumps.
  task automatic run_seq(input bit lstall, input int halt_at, input bit dstall, input bit noise);
    int ldi = 0;
    bit fin = 0;
    logic pv = 0, pr = 0;
    logic [AWD-1:0] pa = '0;
    logic [DW-1:0] pd = '0;
    wa.delete(); wd.delete(); da.delete(); dd.delete();
    run_cyc = 0; stab_err = 0; ld_we_err = 0; last_ld_cyc = -1; first_run_cyc = -1;
    start = 1'b1; step; start = noise;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      load_valid = lstall ? (cyc % 2 == 0) : 1'b1;
      load_data  = (ldi < NINIT) ? words[ldi] : 32'hDEAD_BEEF;
      cpu_halt   = cpu_run ? (halt_at > 0 && run_cyc + 1 == halt_at) : noise;
      dump_ready = dstall ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (load_ready && (mem_we !== load_valid)) ld_we_err++;
      if (mem_we) begin
        wa.push_back(int'(mem_addr)); wd.push_back(mem_wdata);
        if (load_ready) last_ld_cyc = cyc;
      end
      if (load_ready && load_valid) ldi++;
      if (cpu_run) begin
        if (first_run_cyc < 0) first_run_cyc = cyc;
        run_cyc++;
      end
      if (dump_valid) begin
        if (pv && !pr && (dump_addr !== pa || dump_data !== pd)) stab_err++;
        if (dump_ready) begin da.push_back(int'(dump_addr)); dd.push_back(dump_data); end
      end
      pv = dump_valid; pr = dump_ready; pa = dump_addr; pd = dump_data;
      if (done) fin = 1; else step;
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL seq_done: done never seen within budget"); end
    tout_q = timeout; done_q = done;
    load_valid = 0; cpu_halt = 0; dump_ready = 0; start = 0;
  endtask

  task automatic test_reset;
    logic [6:0] o;
    rst_n = 0; step; step;
    o = {busy, done, timeout, cpu_run, mem_we, load_ready, dump_valid};
    checks++; if (o !== 7'b0) begin errors++; $display("FAIL por_outputs: got %b want 0000000", o); end
`ifdef DMEM_CHECKSUM_EN
    checks++; if (dump_sum !== '0) begin errors++; $display("FAIL por_sum: got %0d want 0", dump_sum); end
`endif
    rst_n = 1; step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    // reset mid-CLEAR
    start = 1; step; start = 0;
    repeat (4) step;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL clear_we: got %b want 1", mem_we); end
    rst_n = 0; step;
    o = {busy, done, timeout, cpu_run, mem_we, load_ready, dump_valid};
    checks++; if (o !== 7'b0) begin errors++; $display("FAIL rst_mid_outputs: got %b want 0000000", o); end
    step;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we: got %b want 0", mem_we); end
    rst_n = 1; step;
    o = {busy, done, timeout, cpu_run, mem_we, load_ready, dump_valid};
    checks++; if (o !== 7'b0) begin errors++; $display("FAIL rst_idle: got %b want 0000000", o); end
  endtask

  task automatic test_load;
    run_seq(0, 20, 0, 0);
    checks++; if (wa.size() != DEPTH + NINIT) begin errors++; $display("FAIL load_wr_count: got %0d want %0d", wa.size(), DEPTH + NINIT); end
    for (int i = 0; i < wa.size() && i < DEPTH + NINIT; i++) begin
      int ea = (i < DEPTH) ? i : i - DEPTH;
      logic [DW-1:0] ed = (i < DEPTH) ? '0 : words[i - DEPTH];
      checks++;
      if (wa[i] != ea || wd[i] !== ed) begin
        errors++; $display("FAIL load_wr[%0d]: got a=%0d d=%0d want a=%0d d=%0d", i, wa[i], wd[i], ea, ed);
      end
    end
    checks++; if (first_run_cyc != last_ld_cyc + 1) begin errors++; $display("FAIL run_rise: got cyc %0d want %0d", first_run_cyc, last_ld_cyc + 1); end
  endtask

  task automatic test_load_stall;
    run_seq(1, 20, 0, 0);
    checks++; if (ld_we_err != 0) begin errors++; $display("FAIL stall_we: got %0d mismatched cycles want 0", ld_we_err); end
    checks++; if (wa.size() != DEPTH + NINIT) begin errors++; $display("FAIL stall_wr_count: got %0d want %0d", wa.size(), DEPTH + NINIT); end
    for (int i = 0; i < NINIT && DEPTH + i < wa.size(); i++) begin
      checks++;
      if (wa[DEPTH+i] != i || wd[DEPTH+i] !== words[i]) begin
        errors++; $display("FAIL stall_wr[%0d]: got a=%0d d=%0d want a=%0d d=%0d", i, wa[DEPTH+i], wd[DEPTH+i], i, words[i]);
      end
    end
  endtask

  task automatic test_dump;
    run_seq(0, 20, 1, 0);
    checks++; if (run_cyc != 20) begin errors++; $display("FAIL dump_run_cyc: got %0d want 20", run_cyc); end
    checks++; if (da.size() != DEPTH) begin errors++; $display("FAIL dump_count: got %0d want %0d", da.size(), DEPTH); end
    for (int i = 0; i < da.size() && i < DEPTH; i++) begin
      logic [DW-1:0] ed = (i < NINIT) ? words[i] : '0;
      checks++;
      if (da[i] != i || dd[i] !== ed) begin
        errors++; $display("FAIL dump[%0d]: got a=%0d d=%0d want a=%0d d=%0d", i, da[i], dd[i], i, ed);
      end
    end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL dump_stable: got %0d changes want 0", stab_err); end
    checks++; if (tout_q !== 1'b0) begin errors++; $display("FAIL dump_timeout: got %b want 0", tout_q); end
    checks++; if (done_q !== 1'b1) begin errors++; $display("FAIL dump_done: got %b want 1", done_q); end
  endtask

  // start and cpu_halt held high outside RUN must be ignored
  task automatic test_timeout;
    run_seq(0, 0, 0, 1);
    checks++; if (wa.size() != DEPTH + NINIT) begin errors++; $display("FAIL to_wr_count: got %0d want %0d", wa.size(), DEPTH + NINIT); end
    checks++; if (run_cyc != TO) begin errors++; $display("FAIL to_run_cyc: got %0d want %0d", run_cyc, TO); end
    checks++; if (tout_q !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", tout_q); end
    checks++; if (da.size() != DEPTH) begin errors++; $display("FAIL to_dump_count: got %0d want %0d", da.size(), DEPTH); end
  endtask

  task automatic test_halt_at_expiry;
    run_seq(0, TO, 0, 0);
    checks++; if (run_cyc != TO) begin errors++; $display("FAIL hx_run_cyc: got %0d want %0d", run_cyc, TO); end
    checks++; if (tout_q !== 1'b0) begin errors++; $display("FAIL hx_flag: got %b want 0", tout_q); end
  endtask

`ifdef DMEM_CHECKSUM_EN
  task automatic test_checksum;
    run_seq(0, 20, 1, 0);
    checks++; if (dump_sum !== 32'd1242) begin errors++; $display("FAIL sum_first: got %0d want 1242", dump_sum); end
    run_seq(0, 20, 1, 0);
    checks++; if (dump_sum !== 32'd1242) begin errors++; $display("FAIL sum_second: got %0d want 1242", dump_sum); end
  endtask
`endif

  initial begin
    test_reset;
    test_load;
    test_load_stall;
    test_dump;
    test_timeout;
    test_halt_at_expiry;
`ifdef DMEM_CHECKSUM_EN
    test_checksum;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
